// File: rtl/mer_power_accum_if.sv
// rtl/mer_power_accum_if.sv - symbol input and block-power output bundle for mer_power_accum
interface mer_power_accum_if;
    logic               clk_en;
    logic signed [17:0] decision_i;
    logic signed [17:0] decision_q;
    logic signed [17:0] error_i;
    logic signed [17:0] error_q;
    logic signed [17:0] mapper_power;
    logic signed [17:0] error_power;
    logic               out_valid;
    logic               mapper_sat;
    logic               error_sat;

    modport master (
        output clk_en, decision_i, decision_q, error_i, error_q,
        input  mapper_power, error_power, out_valid, mapper_sat, error_sat
    );

    modport slave (
        input  clk_en, decision_i, decision_q, error_i, error_q,
        output mapper_power, error_power, out_valid, mapper_sat, error_sat
    );
endinterface

// File: rtl/mer_power_accum.sv
// rtl/mer_power_accum.sv - block-averaged decision and error power for the MER LUT
module mer_power_accum #(
    parameter int LOG2_N      = 10,
    parameter int POWER_SHIFT = 22
) (
    input  logic             clk,
    input  logic             reset,
    mer_power_accum_if.slave bus
);
    localparam int ACC_W = 36 + LOG2_N;
    localparam int SHIFT = LOG2_N + POWER_SHIFT;
    localparam logic [ACC_W-1:0]  OUT_MAX  = ACC_W'(131071);
    localparam logic [LOG2_N-1:0] CNT_LAST = '1;

    // E0: sampled symbol
    logic               vld0_q;
    logic signed [17:0] di_q, dq_q, ei_q, eq_q;
    // E1: squares
    logic               vld1_q;
    logic [35:0]        sq_di_q, sq_dq_q, sq_ei_q, sq_eq_q;
    logic [35:0]        sq_di_d, sq_dq_d, sq_ei_d, sq_eq_d;
    // E2: per-symbol powers
    logic               vld2_q;
    logic [35:0]        pd_q, pe_q;
    // E3: accumulation and block dump
    logic [ACC_W-1:0]   acc_dec_q, acc_err_q, acc_dec_d, acc_err_d;
    logic [LOG2_N-1:0]  cnt_q, cnt_d;
    logic [17:0]        mp_q, ep_q, mp_d, ep_d;
    logic               ms_q, es_q, ms_d, es_d;
    logic               ov_q, ov_d;
    logic [ACC_W-1:0]   sum_dec, sum_err, res_dec, res_err;

    // Sign-extend to 36 bits first so -2^17 squares to exactly 2^34.
    function automatic logic [35:0] square(input logic signed [17:0] x);
        logic signed [35:0] xe;
        xe = 36'(x);
        return unsigned'(xe * xe);
    endfunction

    always_comb begin
        sq_di_d = square(di_q);
        sq_dq_d = square(dq_q);
        sq_ei_d = square(ei_q);
        sq_eq_d = square(eq_q);
    end

    always_comb begin
        sum_dec   = acc_dec_q + ACC_W'(pd_q);
        sum_err   = acc_err_q + ACC_W'(pe_q);
        res_dec   = sum_dec >> SHIFT;
        res_err   = sum_err >> SHIFT;
        acc_dec_d = acc_dec_q;
        acc_err_d = acc_err_q;
        cnt_d     = cnt_q;
        mp_d      = mp_q;
        ep_d      = ep_q;
        ms_d      = ms_q;
        es_d      = es_q;
        ov_d      = 1'b0;
        if (vld2_q) begin
            if (cnt_q == CNT_LAST) begin
                acc_dec_d = '0;
                acc_err_d = '0;
                cnt_d     = '0;
                ms_d      = res_dec > OUT_MAX;
                es_d      = res_err > OUT_MAX;
                mp_d      = ms_d ? OUT_MAX[17:0] : res_dec[17:0];
                ep_d      = es_d ? OUT_MAX[17:0] : res_err[17:0];
                ov_d      = 1'b1;
            end else begin
                acc_dec_d = sum_dec;
                acc_err_d = sum_err;
                cnt_d     = cnt_q + LOG2_N'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld0_q    <= 1'b0;
            di_q      <= '0;
            dq_q      <= '0;
            ei_q      <= '0;
            eq_q      <= '0;
            vld1_q    <= 1'b0;
            sq_di_q   <= '0;
            sq_dq_q   <= '0;
            sq_ei_q   <= '0;
            sq_eq_q   <= '0;
            vld2_q    <= 1'b0;
            pd_q      <= '0;
            pe_q      <= '0;
            acc_dec_q <= '0;
            acc_err_q <= '0;
            cnt_q     <= '0;
            mp_q      <= '0;
            ep_q      <= '0;
            ms_q      <= 1'b0;
            es_q      <= 1'b0;
            ov_q      <= 1'b0;
        end else begin
            vld0_q <= bus.clk_en;
            if (bus.clk_en) begin
                di_q <= bus.decision_i;
                dq_q <= bus.decision_q;
                ei_q <= bus.error_i;
                eq_q <= bus.error_q;
            end
            vld1_q    <= vld0_q;
            sq_di_q   <= sq_di_d;
            sq_dq_q   <= sq_dq_d;
            sq_ei_q   <= sq_ei_d;
            sq_eq_q   <= sq_eq_d;
            vld2_q    <= vld1_q;
            pd_q      <= sq_di_q + sq_dq_q;
            pe_q      <= sq_ei_q + sq_eq_q;
            acc_dec_q <= acc_dec_d;
            acc_err_q <= acc_err_d;
            cnt_q     <= cnt_d;
            mp_q      <= mp_d;
            ep_q      <= ep_d;
            ms_q      <= ms_d;
            es_q      <= es_d;
            ov_q      <= ov_d;
        end
    end

    assign bus.mapper_power = signed'(mp_q);
    assign bus.error_power  = signed'(ep_q);
    assign bus.mapper_sat   = ms_q;
    assign bus.error_sat    = es_q;
    assign bus.out_valid    = ov_q;
endmodule

// File: tb/tb_mer_power_accum.sv
// tb/tb_mer_power_accum.sv - randomized and directed bench for mer_power_accum (shift 22 and 16)
module tb_mer_power_accum;
    localparam int N = 1024;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mer_power_accum_if bus_a ();
    mer_power_accum_if bus_b ();

    mer_power_accum #(.LOG2_N(10), .POWER_SHIFT(22)) dut_a (.clk(clk), .reset(reset), .bus(bus_a.slave));
    mer_power_accum #(.LOG2_N(10), .POWER_SHIFT(16)) dut_b (.clk(clk), .reset(reset), .bus(bus_b.slave));

    typedef struct {
        int     due;
        longint mp_a, ep_a, mp_b, ep_b;
        bit     ms_a, es_a, ms_b, es_b;
    } ev_t;

    ev_t    evq[$];
    ev_t    ev;
    int     total = 0;
    int     bad = 0;
    int     edge_cnt = 0;
    bit     chk_on = 1'b0;
    bit     exp_v;
    longint exp_mp_a, exp_ep_a, exp_mp_b, exp_ep_b;
    bit     exp_ms_a, exp_es_a, exp_ms_b, exp_es_b;
    longint sum_d, sum_e;
    int     nsym;
    int     lvl[4] = '{32768, 98304, -32768, -98304};

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_cnt, act, exp);
        end
    endtask

    function automatic void clip(input longint r, output longint v, output bit s);
        s = r > 131071;
        v = s ? 131071 : r;
    endfunction

    function automatic int rnd18();
        logic signed [17:0] v;
        v = 18'($urandom);
        return int'(v);
    endfunction

    // Reference: the block mean power is just the plain sum of |x|^2 over N enabled symbols, shifted.
    task automatic step(input bit rst, input bit en, input int di, input int dq, input int ei, input int eq);
        ev_t e;
        reset = rst;
        bus_a.clk_en = en;  bus_b.clk_en = en;
        bus_a.decision_i = 18'(di); bus_b.decision_i = 18'(di);
        bus_a.decision_q = 18'(dq); bus_b.decision_q = 18'(dq);
        bus_a.error_i    = 18'(ei); bus_b.error_i    = 18'(ei);
        bus_a.error_q    = 18'(eq); bus_b.error_q    = 18'(eq);
        @(posedge clk);
        edge_cnt++;
        if (rst) begin
            sum_d = 0; sum_e = 0; nsym = 0;
            evq.delete();
            exp_mp_a = 0; exp_ep_a = 0; exp_mp_b = 0; exp_ep_b = 0;
            exp_ms_a = 0; exp_es_a = 0; exp_ms_b = 0; exp_es_b = 0;
            chk_on = 1'b1;
        end else if (en) begin
            sum_d += longint'(di) * di + longint'(dq) * dq;
            sum_e += longint'(ei) * ei + longint'(eq) * eq;
            nsym++;
            if (nsym == N) begin
                e.due = edge_cnt + 3;
                clip(sum_d >> 32, e.mp_a, e.ms_a);
                clip(sum_e >> 32, e.ep_a, e.es_a);
                clip(sum_d >> 26, e.mp_b, e.ms_b);
                clip(sum_e >> 26, e.ep_b, e.es_b);
                evq.push_back(e);
                sum_d = 0; sum_e = 0; nsym = 0;
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            exp_v = 1'b0;
            if (evq.size() > 0 && evq[0].due == edge_cnt) begin
                ev = evq.pop_front();
                exp_v = 1'b1;
                exp_mp_a = ev.mp_a; exp_ep_a = ev.ep_a; exp_ms_a = ev.ms_a; exp_es_a = ev.es_a;
                exp_mp_b = ev.mp_b; exp_ep_b = ev.ep_b; exp_ms_b = ev.ms_b; exp_es_b = ev.es_b;
            end
            chk("valid_a", bus_a.out_valid, exp_v);
            chk("valid_b", bus_b.out_valid, exp_v);
            chk("mp_a", bus_a.mapper_power, exp_mp_a);
            chk("ep_a", bus_a.error_power, exp_ep_a);
            chk("msat_a", bus_a.mapper_sat, exp_ms_a);
            chk("esat_a", bus_a.error_sat, exp_es_a);
            chk("mp_b", bus_b.mapper_power, exp_mp_b);
            chk("ep_b", bus_b.error_power, exp_ep_b);
            chk("msat_b", bus_b.mapper_sat, exp_ms_b);
            chk("esat_b", bus_b.error_sat, exp_es_b);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, rnd18(), rnd18(), rnd18(), rnd18());
    endtask

    task automatic block_const(input int di, input int dq, input int ei, input int eq);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, di, dq, ei, eq);
    endtask

    initial begin
        step(1'b1, 1'b0, 0, 0, 0, 0);
        step(1'b1, 1'b0, 0, 0, 0, 0);
        chk("lit_reset_mp", bus_a.mapper_power, 0);
        chk("lit_reset_valid", bus_a.out_valid, 0);

        for (int i = 0; i < N; i++) step(1'b0, 1'b1, 32768, 32768, 0, 0);
        step(1'b0, 1'b0, 0, 0, 0, 0);
        chk("lit_t1_lat1", bus_a.out_valid, 0);
        step(1'b0, 1'b0, 0, 0, 0, 0);
        chk("lit_t1_lat2", bus_a.out_valid, 0);
        step(1'b0, 1'b0, 0, 0, 0, 0);
        chk("lit_t1_lat3", bus_a.out_valid, 1);
        step(1'b0, 1'b0, 0, 0, 0, 0);
        chk("lit_t1_pulse", bus_a.out_valid, 0);
        chk("lit_t1_mp", bus_a.mapper_power, 512);
        chk("lit_t1_ep", bus_a.error_power, 0);
        chk("lit_t1_sat", bus_a.mapper_sat, 0);
        chk("lit_t1_mp_b", bus_b.mapper_power, 32768);

        block_const(32768, 32768, 4096, 4096); idle(4);
        chk("lit_t2_ep8", bus_a.error_power, 8);
        block_const(32768, 32768, 2048, 0); idle(4);
        chk("lit_t2_ep1", bus_a.error_power, 1);
        block_const(32768, 32768, 2047, 0); idle(4);
        chk("lit_t2_ep0", bus_a.error_power, 0);

        block_const(-131072, -131072, -131072, -131072); idle(4);
        chk("lit_t3_mp", bus_a.mapper_power, 8192);
        chk("lit_t3_ep", bus_a.error_power, 8192);
        chk("lit_t3_sat", bus_a.mapper_sat, 0);
        chk("lit_t3_mp_b", bus_b.mapper_power, 131071);
        chk("lit_t3_msat_b", bus_b.mapper_sat, 1);
        chk("lit_t3_esat_b", bus_b.error_sat, 1);

        for (int i = 0; i < N; i++) step(1'b0, 1'b1, lvl[i % 4], lvl[(i / 4) % 4], 0, 0);
        idle(4);
        chk("lit_t4_qam", bus_a.mapper_power, 2560);
        for (int i = 0; i < N; i++) begin
            step(1'b0, 1'b1, lvl[i % 4], lvl[(i / 4) % 4], 0, 0);
            idle(2);
        end
        idle(2);
        chk("lit_t4_qam_sparse", bus_a.mapper_power, 2560);

        for (int i = 0; i < 500; i++) step(1'b0, 1'b1, rnd18(), rnd18(), rnd18(), rnd18());
        step(1'b1, 1'b1, 98304, 98304, 0, 0);
        chk("lit_t5_rst_mp", bus_a.mapper_power, 0);
        chk("lit_t5_rst_sat", bus_b.mapper_sat, 0);
        idle(3);
        for (int i = 0; i < N; i++) step(1'b0, 1'b1, rnd18(), rnd18(), rnd18(), rnd18());
        idle(4);

        block_const(32768, 0, 0, 0); idle(10);
        chk("lit_t6_first", bus_a.mapper_power, 256);
        block_const(98304, 98304, 32768, 0); idle(4);
        chk("lit_t6_second_mp", bus_a.mapper_power, 4608);
        chk("lit_t6_second_ep", bus_a.error_power, 256);

        for (int k = 0; k < 2 * N; ) begin
            if ($urandom_range(1, 0) == 1) begin
                step(1'b0, 1'b1, rnd18(), rnd18(), rnd18(), rnd18());
                k++;
            end else begin
                idle(1);
            end
        end
        idle(5);
        chk("pending_events", evq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
